// File: rtl/twos_pkg.sv
// rtl/twos_pkg.sv - shared mode and FSM state encodings for the serial two's-complement unit
//
// Purpose : constants shared by twos_comp_serial and its bench.
// Contents: MODE_* operation select codes, S_* FSM state encodings.
package twos_pkg;

  // Operation select carried on in_mode
  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_NEG  = 2'b01;
  localparam logic [1:0] MODE_ABS  = 2'b10;
  localparam logic [1:0] MODE_INV  = 2'b11;

  // FSM states
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/twos_digit.sv
// rtl/twos_digit.sv - one DIGIT-bit slice of the conditional-invert-and-increment chain
//
// Purpose : combinational slice; optionally inverts a digit and adds the incoming carry.
// Ports   : op_digit  in  DIGIT  operand digit
//           inv       in  1      invert op_digit before the add
//           cin       in  1      carry in from the previous (less significant) digit
//           res_digit out DIGIT  result digit
//           cout      out 1      carry out to the next digit
module twos_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] op_digit,
  input  logic             inv,
  input  logic             cin,
  output logic [DIGIT-1:0] res_digit,
  output logic             cout
);

  logic [DIGIT-1:0] d;

  always_comb begin
    d = inv ? ~op_digit : op_digit;
    {cout, res_digit} = {1'b0, d} + {{DIGIT{1'b0}}, cin};
  end

endmodule

// File: rtl/twos_comp_serial.sv
// rtl/twos_comp_serial.sv - digit-serial pass / negate / abs / one's-complement unit
//
// Purpose : transforms a WIDTH-bit two's-complement word DIGIT bits per cycle, LSB first,
//           with a registered carry between digits. Flags NEG/ABS of the most-negative value.
// Ports   : clk        in   1      clock, rising edge
//           rst        in   1      synchronous active-high reset
//           in_valid   in   1      operand valid
//           in_ready   out  1      high only in IDLE
//           in_data    in   WIDTH  operand
//           in_mode    in   2      00 PASS, 01 NEG, 10 ABS, 11 INV
//           out_valid  out  1      high only in DONE
//           out_ready  in   1      consumer accepts result
//           out_data   out  WIDTH  result
//           out_ovf    out  1      NEG/ABS of the most-negative input
module twos_comp_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  import twos_pkg::*;

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0]    LAST    = CW'(NDIG - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("twos_comp_serial: illegal WIDTH/DIGIT combination");
  end

  logic [1:0]       state_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             inv_q;
  logic             ovf_q;
  logic [WIDTH-1:0] op_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_next;
  logic [DIGIT-1:0] res_digit;
  logic             cout;
  logic             in_neg;
  logic             in_ovf;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = res_q;
  assign out_ovf   = ovf_q;

  // Negation is invert-then-add-one; the +1 enters as the initial carry.
  assign in_neg = (in_mode == MODE_NEG) | ((in_mode == MODE_ABS) & in_data[WIDTH-1]);
  assign in_ovf = ((in_mode == MODE_NEG) | (in_mode == MODE_ABS)) & (in_data == MIN_VAL);

  twos_digit #(.DIGIT(DIGIT)) u_digit (
    .op_digit  (op_q[DIGIT-1:0]),
    .inv       (inv_q),
    .cin       (carry_q),
    .res_digit (res_digit),
    .cout      (cout)
  );

  // Result fills from the MSB side so the first (least significant) digit ends up at bit 0.
  if (DIGIT == WIDTH) begin : g_res_full
    assign res_next = res_digit;
  end else begin : g_res_shift
    assign res_next = {res_digit, res_q[WIDTH-1:DIGIT]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      inv_q   <= 1'b0;
      ovf_q   <= 1'b0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_q    <= in_data;
            inv_q   <= in_neg | (in_mode == MODE_INV);
            carry_q <= in_neg;
            ovf_q   <= in_ovf;
            cnt_q   <= '0;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          res_q   <= res_next;
          op_q    <= op_q >> DIGIT;
          carry_q <= cout;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_twos_comp_serial.sv
// tb/tb_twos_comp_serial.sv - self-checking bench: directed vectors plus parameter sweep vs reference model
module tb_twos_comp_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  twos_comp_serial #(.WIDTH(8), .DIGIT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one operand, wait for out_valid and check result, flag and latency.
  // Caller is positioned 1 time unit after a rising edge with in_ready high.
  task automatic do_op(input string tag, input logic [1:0] mode, input logic [7:0] data,
                       input logic [7:0] exp_data, input logic exp_ovf);
    int  lat;
    bit  rdy_seen;
    in_valid = 1'b1;
    in_mode  = mode;
    in_data  = data;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'hxx;
    lat      = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready) rdy_seen = 1'b1;
    check({tag, "_lat"},   lat, 5);
    check({tag, "_rdy"},   rdy_seen, 0);
    check({tag, "_data"},  out_data, exp_data);
    check({tag, "_ovf"},   out_ovf, exp_ovf);
    if (out_ready) begin
      @(posedge clk); #1;
      check({tag, "_vld1"}, out_valid, 0);
      check({tag, "_idle"}, in_ready, 1);
    end
  endtask

  // Parameter sweep: three further instances checked against an arithmetic reference.
  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int W    = (g == 2) ? 16 : 8;
    localparam int D    = (g == 0) ? 1 : (g == 1) ? 8 : 4;
    localparam int NLAT = W / D + 1;
    localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

    logic         s_rst;
    logic         s_in_valid;
    logic         s_in_ready;
    logic [W-1:0] s_in_data;
    logic [1:0]   s_in_mode;
    logic         s_out_valid;
    logic         s_out_ready;
    logic [W-1:0] s_out_data;
    logic         s_out_ovf;
    logic         done = 1'b0;

    twos_comp_serial #(.WIDTH(W), .DIGIT(D)) dut_s (
      .clk       (clk),
      .rst       (s_rst),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .in_data   (s_in_data),
      .in_mode   (s_in_mode),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .out_data  (s_out_data),
      .out_ovf   (s_out_ovf)
    );

    initial begin
      logic [W-1:0] a;
      logic [W-1:0] e;
      logic [1:0]   m;
      logic         e_ovf;
      int           lat;
      s_rst       = 1'b1;
      s_in_valid  = 1'b0;
      s_in_data   = '0;
      s_in_mode   = 2'b00;
      s_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 s_rst = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        m = 2'($urandom_range(3, 0));
        a = W'($urandom);
        if (i % 16 == 0) a = MINV;
        if (i % 16 == 1) a = '0;
        case (m)
          2'b00:   e = a;
          2'b01:   e = -a;
          2'b10:   e = a[W-1] ? -a : a;
          default: e = ~a;
        endcase
        e_ovf = (m == 2'b01 || m == 2'b10) && (a == MINV);
        s_in_valid = 1'b1;
        s_in_mode  = m;
        s_in_data  = a;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        lat = 1;
        while (!s_out_valid && lat < 40) begin
          @(posedge clk); #1;
          lat++;
        end
        check($sformatf("sweep%0d_lat", g),  lat, NLAT);
        check($sformatf("sweep%0d_data", g), 32'(s_out_data), 32'(e));
        check($sformatf("sweep%0d_ovf", g),  s_out_ovf, e_ovf);
        @(posedge clk); #1;
      end
      done = 1'b1;
    end
  end

  initial begin
    logic [7:0] held;
    bit         bad_rdy;
    bit         bad_data;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_mode   = 2'b00;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data, 0);
    check("rst_out_ovf",   out_ovf, 0);
    rst = 1'b0;

    do_op("neg05", 2'b01, 8'h05, 8'hFB, 1'b0);
    do_op("neg80", 2'b01, 8'h80, 8'h80, 1'b1);
    do_op("abs80", 2'b10, 8'h80, 8'h80, 1'b1);
    do_op("neg00", 2'b01, 8'h00, 8'h00, 1'b0);
    do_op("absF3", 2'b10, 8'hF3, 8'h0D, 1'b0);
    do_op("abs2A", 2'b10, 8'h2A, 8'h2A, 1'b0);
    do_op("inv5A", 2'b11, 8'h5A, 8'hA5, 1'b0);
    do_op("pass7F", 2'b00, 8'h7F, 8'h7F, 1'b0);

    // Backpressure: result must hold and new operands must be refused.
    out_ready = 1'b0;
    do_op("bp_neg10", 2'b01, 8'h10, 8'hF0, 1'b0);
    held     = out_data;
    bad_rdy  = 1'b0;
    bad_data = 1'b0;
    in_valid = 1'b1;
    in_mode  = 2'b00;
    in_data  = 8'h3C;
    repeat (6) begin
      @(posedge clk); #1;
      if (in_ready || !out_valid) bad_rdy = 1'b1;
      if (out_data !== held) bad_data = 1'b1;
    end
    check("bp_ready_low", bad_rdy, 0);
    check("bp_data_hold", bad_data, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_rel_ready", in_ready, 1);
    check("bp_rel_valid", out_valid, 0);
    check("bp_rel_data",  out_data, 8'hF0);
    @(posedge clk); #1;
    check("bp_no_capture", in_ready, 1);

    // Reset during the second BUSY cycle aborts the operation.
    in_valid = 1'b1;
    in_mode  = 2'b01;
    in_data  = 8'h33;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready", in_ready, 1);
    check("abort_valid", out_valid, 0);
    check("abort_data",  out_data, 0);
    check("abort_ovf",   out_ovf, 0);
    do_op("neg01", 2'b01, 8'h01, 8'hFF, 1'b0);

    // Simultaneous reset and in_valid: reset wins.
    rst      = 1'b1;
    in_valid = 1'b1;
    in_mode  = 2'b01;
    in_data  = 8'h07;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_wins_idle", in_ready, 1);

    for (int t = 0; t < 60000 && !(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done); t++)
      @(posedge clk);
    check("sweep_done", {g_sweep[0].done, g_sweep[1].done, g_sweep[2].done}, 3'b111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
